// File: rtl/svga_timing_detector.sv
// svga_timing_detector
//   Recovers raster timing from h_synch / v_synch / composite blank:
//   measures line and frame sizes, regenerates per-pixel coordinates
//   with a data-enable, and reports lock after LOCK_FRAMES matching frames.
module svga_timing_detector #(
  parameter int HW          = 11,
  parameter int VW          = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          pixel_clock,
  input  logic          reset,
  input  logic          h_synch_in,
  input  logic          v_synch_in,
  input  logic          blank_in,
  output logic          de,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] line_y,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          locked,
  output logic          frame_start,
  output logic          timing_change
);

  localparam logic [HW-1:0] H_MAX  = '1;
  localparam logic [VW-1:0] V_MAX  = '1;
  localparam logic [4:0]    LOCK_N = 5'(LOCK_FRAMES);

  logic          h_q, v_q, b_q;
  logic          h_rise, v_rise, b_rise, line_done;
  logic [HW-1:0] h_cnt, h_period, h_next;
  logic [HW-1:0] a_cnt, line_act;
  logic [VW-1:0] al_cnt, v_lines;
  logic          h_seen, l_seen, frame_bad, first_frame;
  logic [3:0]    match_cnt;
  logic [4:0]    match_inc;
  logic          meas_eq, timeout;

  assign h_rise    = h_synch_in & ~h_q;
  assign v_rise    = v_synch_in & ~v_q;
  assign b_rise    = blank_in & ~b_q;
  // an active line ends on a blank rising edge that followed some active pixels
  assign line_done = b_rise & (a_cnt != '0);
  assign h_next    = h_cnt + 1'b1;
  assign match_inc = {1'b0, match_cnt} + 5'd1;
  // v_lines / al_cnt are the frame's measurements at the v_rise instant
  assign meas_eq   = (h_period == h_total) && (line_act == h_active) &&
                     (v_lines == v_total) && (al_cnt == v_active);
  assign timeout   = (h_cnt == H_MAX) || (v_lines == V_MAX);

  // input registers for edge detection
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h_q <= 1'b0;
      v_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      h_q <= h_synch_in;
      v_q <= v_synch_in;
      b_q <= blank_in;
    end
  end

  // line / frame counters and per-frame consistency tracking
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h_cnt     <= '0;
      h_period  <= '0;
      a_cnt     <= '0;
      line_act  <= '0;
      al_cnt    <= '0;
      v_lines   <= '0;
      h_seen    <= 1'b0;
      l_seen    <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      if (h_rise) begin
        h_period <= h_next;
        h_cnt    <= '0;
      end else if (h_cnt != H_MAX) begin
        h_cnt <= h_next;
      end

      if (blank_in)            a_cnt <= '0;
      else if (a_cnt != H_MAX) a_cnt <= a_cnt + 1'b1;

      if (line_done) line_act <= a_cnt;

      if (v_rise)                             al_cnt <= '0;
      else if (line_done && al_cnt != V_MAX)  al_cnt <= al_cnt + 1'b1;

      if (v_rise)                             v_lines <= h_rise ? VW'(1) : '0;
      else if (h_rise && v_lines != V_MAX)    v_lines <= v_lines + 1'b1;

      // a coincident h_rise is the first line of the new frame, not a compare
      if (v_rise)      h_seen <= h_rise;
      else if (h_rise) h_seen <= 1'b1;

      if (v_rise)         l_seen <= line_done;
      else if (line_done) l_seen <= 1'b1;

      if (v_rise)
        frame_bad <= 1'b0;
      else if ((h_rise && h_seen && h_next != h_period) ||
               (line_done && l_seen && a_cnt != line_act))
        frame_bad <= 1'b1;
    end
  end

  // frame evaluation: update measurements, count matches, manage lock
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      first_frame   <= 1'b1;
      match_cnt     <= '0;
      locked        <= 1'b0;
      h_total       <= '0;
      h_active      <= '0;
      v_total       <= '0;
      v_active      <= '0;
      timing_change <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      timing_change <= 1'b0;
      frame_start   <= v_rise;
      if (v_rise) begin
        if (first_frame) begin
          // partial frame after reset/timeout: discard
          first_frame <= 1'b0;
        end else if (!frame_bad && meas_eq) begin
          if ({1'b0, match_cnt} < LOCK_N) match_cnt <= match_cnt + 1'b1;
          if (match_inc >= LOCK_N)        locked    <= 1'b1;
        end else begin
          h_total       <= h_period;
          h_active      <= line_act;
          v_total       <= v_lines;
          v_active      <= al_cnt;
          match_cnt     <= '0;
          locked        <= 1'b0;
          timing_change <= 1'b1;
        end
      end
      // lost sync: drop lock, keep the last measurements
      if (timeout) begin
        locked      <= 1'b0;
        match_cnt   <= '0;
        first_frame <= 1'b1;
      end
    end
  end

  // regenerated coordinates, one clock behind blank_in
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      de      <= 1'b0;
      pixel_x <= '0;
      line_y  <= '0;
    end else begin
      de <= ~blank_in;
      if (!blank_in) begin
        pixel_x <= a_cnt;
        line_y  <= al_cnt;
      end
    end
  end

endmodule

// File: tb/tb_svga_timing_detector.sv
// tb_svga_timing_detector
//   Directed bench on a scaled raster (64 clk/line, 48 active, 24 lines,
//   18 active) so a full lock sequence fits a short run; the detector only
//   measures, so the same behaviour holds for the full 800x600 raster.
module tb_svga_timing_detector;

  localparam int HT = 64, HA = 48, HS_STD = 52, HS_ALN = 0, HSW = 6;
  localparam int VT = 24, VA = 18, VS0 = 19, VSW = 2;

  logic        pixel_clock = 1'b0;
  logic        reset;
  logic        h_synch_in, v_synch_in, blank_in;
  logic        de, locked, frame_start, timing_change;
  logic [10:0] pixel_x, h_total, h_active;
  logic [9:0]  line_y, v_total, v_active;

  int total = 0;
  int bad   = 0;

  // snapshots around the v_synch rising pixel
  logic s_tc, s_tc2, s_lk, s_lk_pre, s_fs, lk_prev;
  int   de_cnt;

  svga_timing_detector dut (
    .pixel_clock  (pixel_clock),
    .reset        (reset),
    .h_synch_in   (h_synch_in),
    .v_synch_in   (v_synch_in),
    .blank_in     (blank_in),
    .de           (de),
    .pixel_x      (pixel_x),
    .line_y       (line_y),
    .h_total      (h_total),
    .h_active     (h_active),
    .v_total      (v_total),
    .v_active     (v_active),
    .locked       (locked),
    .frame_start  (frame_start),
    .timing_change(timing_change)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // one pixel clock; outputs are sampled 1 time unit after the edge
  task automatic px(input logic h, input logic v, input logic b);
    h_synch_in = h;
    v_synch_in = v;
    blank_in   = b;
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic run_lines(input int vs, input int ve, input int hs0,
                           input int short_v, input bit coord);
    for (int vc = vs; vc < ve; vc++) begin
      int hlen;
      hlen = (vc == short_v) ? HT - 1 : HT;
      for (int hc = 0; hc < hlen; hc++) begin
        logic act, hsy, vsy;
        act = (hc < HA) && (vc < VA);
        hsy = (hc >= hs0) && (hc < hs0 + HSW);
        vsy = (vc >= VS0) && (vc < VS0 + VSW);
        px(hsy, vsy, ~act);
        if (vc == VS0 && hc == 0) begin
          s_tc     = timing_change;
          s_lk     = locked;
          s_fs     = frame_start;
          s_lk_pre = lk_prev;
        end
        if (vc == VS0 && hc == 1) s_tc2 = timing_change;
        lk_prev = locked;
        if (coord) begin
          if (de) de_cnt++;
          if (vc == 0 && hc == 0) begin
            chk("first_de", de, 1);
            chk("first_x", pixel_x, 0);
            chk("first_y", line_y, 0);
          end
          if (vc == VA - 1 && hc == HA - 1) begin
            chk("last_x", pixel_x, HA - 1);
            chk("last_y", line_y, VA - 1);
          end
        end
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_x"}, pixel_x, 0);
    chk({tag, "_y"}, line_y, 0);
    chk({tag, "_meas"}, {h_total, h_active, v_total, v_active}, 0);
    chk({tag, "_flags"}, {locked, frame_start, timing_change}, 0);
  endtask

  task automatic chk_meas(input string tag);
    chk({tag, "_ht"}, h_total, HT);
    chk({tag, "_ha"}, h_active, HA);
    chk({tag, "_vt"}, v_total, VT);
    chk({tag, "_va"}, v_active, VA);
  endtask

  initial begin
    lk_prev = 1'b0;
    de_cnt  = 0;
    reset   = 1'b1;
    repeat (3) px(1'b0, 1'b0, 1'b1);
    chk_zero("rst");
    reset = 1'b0;

    // lock sequence on the standard pattern
    run_lines(0, VT, HS_STD, -1, 1'b0);
    chk("f1_fs", s_fs, 1);
    chk("f1_tc", s_tc, 0);
    chk("f1_ht", h_total, 0);
    run_lines(0, VT, HS_STD, -1, 1'b0);
    chk("f2_tc", s_tc, 1);
    chk("f2_tc_pulse", s_tc2, 0);
    chk("f2_lk", s_lk, 0);
    chk_meas("f2");
    run_lines(0, VT, HS_STD, -1, 1'b0);
    chk("f3_tc", s_tc, 0);
    chk("f3_lk", s_lk, 0);
    run_lines(0, VT, HS_STD, -1, 1'b0);
    chk("f4_lk_pre", s_lk_pre, 0);
    chk("f4_lk", s_lk, 1);

    // coordinates on a locked stream
    de_cnt = 0;
    run_lines(0, VT, HS_STD, -1, 1'b1);
    chk("f5_de_cnt", de_cnt, HA * VA);
    chk("f5_lk", s_lk, 1);
    chk("f5_tc", s_tc, 0);

    // one short line drops lock, two good frames relock
    run_lines(0, VT, HS_STD, 5, 1'b0);
    chk("f6_lk_pre", s_lk_pre, 1);
    chk("f6_lk", s_lk, 0);
    chk("f6_tc", s_tc, 1);
    chk_meas("f6");
    run_lines(0, VT, HS_STD, -1, 1'b0);
    chk("f7_lk", s_lk, 0);
    run_lines(0, VT, HS_STD, -1, 1'b0);
    chk("f8_lk", s_lk, 1);

    // h_synch lost long enough to saturate the line counter
    repeat (2100) px(1'b0, 1'b0, 1'b1);
    chk("to_lk", locked, 0);
    chk_meas("to");

    // reset mid-frame, then aligned pattern (v_rise coincident with h_rise)
    run_lines(0, 10, HS_ALN, -1, 1'b0);
    reset = 1'b1;
    repeat (3) px(1'b0, 1'b0, 1'b1);
    chk_zero("mid_rst");
    reset = 1'b0;
    run_lines(10, VT, HS_ALN, -1, 1'b0);
    chk("r1_tc", s_tc, 0);
    chk("r1_ht", h_total, 0);
    run_lines(0, VT, HS_ALN, -1, 1'b0);
    chk("r2_tc", s_tc, 1);
    chk_meas("r2");
    run_lines(0, VT, HS_ALN, -1, 1'b0);
    chk("r3_lk", s_lk, 0);
    run_lines(0, VT, HS_ALN, -1, 1'b0);
    chk("r4_lk_pre", s_lk_pre, 0);
    chk("r4_lk", s_lk, 1);
    chk("r4_vt", v_total, VT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
